// File: rtl/rx_byte_packer_if.sv
// rtl/rx_byte_packer_if.sv - byte input, FIFO write and status signals of the RX byte packer
interface rx_byte_packer_if;
  logic         rx_valid;
  logic [7:0]   rx_byte;
  logic         fifo_full;
  logic         clr_err;
  logic         wr_en;
  logic [255:0] fifo_data;
  logic [5:0]   byte_count;
  logic         overrun;
  logic         timeout_err;

  modport master (
    output rx_valid, rx_byte, fifo_full, clr_err,
    input  wr_en, fifo_data, byte_count, overrun, timeout_err
  );

  modport slave (
    input  rx_valid, rx_byte, fifo_full, clr_err,
    output wr_en, fifo_data, byte_count, overrun, timeout_err
  );
endinterface

// File: rtl/rx_byte_packer.sv
// rtl/rx_byte_packer.sv - packs UART bytes into 256-bit words through an assembler and a hold stage
module rx_byte_packer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic             clk,
  input logic             rst,
  rx_byte_packer_if.slave bus
);

  localparam int IW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [5:0]    FULL      = 6'd32;

  logic [255:0]  asm_q;
  logic [255:0]  hold_q;
  logic [255:0]  data_q;
  logic [5:0]    cnt_q;
  logic          hold_valid_q;
  logic          wr_en_q;
  logic          overrun_q;
  logic          timeout_q;
  logic [IW-1:0] idle_q;

  logic asm_full;
  logic drain;
  logic xfer;
  logic accept;
  logic drop;
  logic tmo;

  // A full assembler may hand off on the same edge the hold register drains,
  // which also frees a slot for the byte arriving on that edge.
  always_comb begin
    asm_full = (cnt_q == FULL);
    drain    = hold_valid_q && !bus.fifo_full;
    xfer     = asm_full && (!hold_valid_q || drain);
    accept   = bus.rx_valid && (!asm_full || xfer);
    drop     = bus.rx_valid && !accept;
    tmo      = (TIMEOUT_CYCLES != 0) && !asm_full && (cnt_q != 6'd0) && (idle_q == IDLE_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      asm_q  <= '0;
      cnt_q  <= '0;
      idle_q <= '0;
    end else begin
      if (accept) begin
        asm_q <= {asm_q[247:0], bus.rx_byte};
      end
      if (xfer || tmo) begin
        cnt_q <= accept ? 6'd1 : 6'd0;
      end else if (accept) begin
        cnt_q <= cnt_q + 6'd1;
      end
      if (accept || tmo || (cnt_q == 6'd0) || asm_full || (TIMEOUT_CYCLES == 0)) begin
        idle_q <= '0;
      end else begin
        idle_q <= idle_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      wr_en_q      <= 1'b0;
      data_q       <= '0;
    end else begin
      wr_en_q <= drain;
      if (drain) begin
        data_q <= hold_q;
      end
      if (xfer) begin
        hold_q       <= asm_q;
        hold_valid_q <= 1'b1;
      end else if (drain) begin
        hold_valid_q <= 1'b0;
      end
    end
  end

  // Sticky flags: a new event on the clearing edge keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (drop) begin
        overrun_q <= 1'b1;
      end else if (bus.clr_err) begin
        overrun_q <= 1'b0;
      end
      if (tmo) begin
        timeout_q <= 1'b1;
      end else if (bus.clr_err) begin
        timeout_q <= 1'b0;
      end
    end
  end

  assign bus.wr_en       = wr_en_q;
  assign bus.fifo_data   = data_q;
  assign bus.byte_count  = cnt_q;
  assign bus.overrun     = overrun_q;
  assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_rx_byte_packer.sv
// tb/tb_rx_byte_packer.sv - randomized bench for rx_byte_packer with a byte-queue word model
module tb_rx_byte_packer;
  localparam int TMO = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rx_byte_packer_if bus();

  rx_byte_packer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total  = 0;
  int bad    = 0;
  int cyc    = 0;
  int wr_cnt = 0;
  int wr_cyc = 0;

  logic [255:0] exp_q[$];
  logic [7:0]   byte_buf[$];

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Every 32 accepted bytes form one word, first byte in the top byte lane.
  function automatic void model_push(input logic [7:0] b);
    logic [255:0] w;
    byte_buf.push_back(b);
    if (byte_buf.size() == 32) begin
      w = '0;
      for (int i = 0; i < 32; i++) w[255 - 8*i -: 8] = byte_buf[i];
      exp_q.push_back(w);
      byte_buf.delete();
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst && bus.wr_en) begin
      wr_cnt++;
      wr_cyc = cyc;
      if (exp_q.size() == 0) chk("unexpected_wr", 1, 0);
      else chk("word", bus.fifo_data, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] b, input bit keep);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
    tick();
    bus.rx_valid = 1'b0;
    if (keep) model_push(b);
  endtask

  task automatic wait_writes(input string tag, input int target, input int budget);
    int left;
    left = budget;
    while (wr_cnt < target && left > 0) begin
      tick();
      left--;
    end
    chk(tag, wr_cnt, target);
  endtask

  task automatic chk_zero(input string t);
    chk({t, "_wr_en"}, bus.wr_en, 0);
    chk({t, "_fifo_data"}, bus.fifo_data, 0);
    chk({t, "_byte_count"}, bus.byte_count, 0);
    chk({t, "_overrun"}, bus.overrun, 0);
    chk({t, "_timeout_err"}, bus.timeout_err, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] w0;
    int e_cyc;
    int sent;
    int wr_base;
    int inflight;
    int budget;

    bus.rx_valid  = 1'b0;
    bus.rx_byte   = 8'h00;
    bus.fifo_full = 1'b0;
    bus.clr_err   = 1'b0;

    #12;
    chk_zero("por");
    tick();
    rst = 1'b1;

    // Ascending bytes: word contents, latency and single pulse.
    for (int i = 0; i < 32; i++) send(8'(i), 1'b1);
    e_cyc = cyc;
    chk("t1_count32", bus.byte_count, 32);
    wait_writes("t1_wr", 1, 10);
    chk("t1_latency", wr_cyc - e_cyc, 2);
    idle(3);
    chk("t1_single_pulse", wr_cnt, 1);
    w0 = '0;
    for (int i = 0; i < 32; i++) w0[255 - 8*i -: 8] = 8'(i);
    chk("t1_data_held", bus.fifo_data, w0);
    chk("t1_wr_low", bus.wr_en, 0);

    // Full FIFO: 64 bytes buffered, 65th dropped, clear vs set priority.
    bus.fifo_full = 1'b1;
    for (int i = 0; i < 64; i++) send(8'($urandom), 1'b1);
    idle(3);
    chk("t2_no_wr", wr_cnt, 1);
    chk("t2_count", bus.byte_count, 32);
    chk("t2_overrun_clear", bus.overrun, 0);
    send(8'($urandom), 1'b0);
    chk("t2_overrun_set", bus.overrun, 1);
    chk("t2_count_after_drop", bus.byte_count, 32);
    bus.clr_err = 1'b1;
    send(8'($urandom), 1'b0);
    bus.clr_err = 1'b0;
    chk("t2_set_wins", bus.overrun, 1);
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    chk("t2_cleared", bus.overrun, 0);
    bus.fifo_full = 1'b0;
    wait_writes("t2_two_words", 3, 20);
    chk("t2_drained", exp_q.size(), 0);

    // Inter-byte timeout on a partial word.
    for (int i = 0; i < 5; i++) send(8'($urandom), 1'b1);
    idle(TMO - 1);
    chk("t3_count_before", bus.byte_count, 5);
    chk("t3_terr_before", bus.timeout_err, 0);
    idle(1);
    chk("t3_count_discard", bus.byte_count, 0);
    chk("t3_terr_set", bus.timeout_err, 1);
    byte_buf.delete();
    chk("t3_no_wr", wr_cnt, 3);
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    chk("t3_terr_cleared", bus.timeout_err, 0);
    for (int i = 0; i < 32; i++) send(8'($urandom), 1'b1);
    wait_writes("t3_clean_word", 4, 10);

    // 96 back-to-back bytes.
    for (int i = 0; i < 96; i++) send(8'($urandom), 1'b1);
    wait_writes("t4_three_words", 7, 20);
    chk("t4_overrun", bus.overrun, 0);
    chk("t4_count", bus.byte_count, 0);

    // Asynchronous reset mid-word.
    for (int i = 0; i < 20; i++) send(8'($urandom), 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk_zero("rst_mid");
    byte_buf.delete();
    tick();
    rst = 1'b1;
    send(8'($urandom), 1'b1);
    chk("t5_first_byte", bus.byte_count, 1);
    for (int i = 0; i < 31; i++) send(8'($urandom), 1'b1);
    wait_writes("t5_word", 8, 10);

    // Asynchronous reset with hold full and overrun set.
    bus.fifo_full = 1'b1;
    for (int i = 0; i < 64; i++) send(8'($urandom), 1'b1);
    send(8'($urandom), 1'b0);
    chk("t5_overrun_pre", bus.overrun, 1);
    #2;
    rst = 1'b0;
    #1;
    chk_zero("rst_hold");
    exp_q.delete();
    byte_buf.delete();
    bus.fifo_full = 1'b0;
    tick();
    rst = 1'b1;
    idle(10);
    chk("t5_no_wr_after_rst", wr_cnt, 8);
    for (int i = 0; i < 32; i++) send(8'($urandom), 1'b1);
    wait_writes("t5_one_word", 9, 10);
    idle(3);
    chk("t5_exactly_one", wr_cnt, 9);

    // Random gaps and random backpressure, throttled so no byte is dropped.
    wr_base = wr_cnt;
    sent    = 0;
    budget  = 20000;
    while (sent < 320 && budget > 0) begin
      bus.fifo_full = ($urandom_range(0, 2) == 0);
      inflight = sent - 32 * (wr_cnt - wr_base);
      if (inflight < 64) begin
        send(8'($urandom), 1'b1);
        sent++;
      end else begin
        tick();
      end
      repeat ($urandom_range(0, 2)) begin
        bus.fifo_full = ($urandom_range(0, 2) == 0);
        tick();
      end
      budget--;
    end
    bus.fifo_full = 1'b0;
    chk("t6_sent", sent, 320);
    wait_writes("t6_words", wr_base + 10, 50);
    chk("t6_drained", exp_q.size(), 0);
    chk("t6_overrun", bus.overrun, 0);
    chk("t6_timeout", bus.timeout_err, 0);
    chk("t6_count", bus.byte_count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
